uart_rx_fifo: RTL

Parametrised UART receiver, next generation of the project's fixed 8N1 receiver.
- Generic baud divisor and data width.
- Start-bit glitch rejection, framing and overrun detection.
- Small first-word-fall-through receive FIFO, so the consumer (command processor) may lag several frames without data loss.
- Sits between the external RX pin and the command-processing logic.

---
 rtl/uart_rx_fifo.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-glitch rejection, framing/overrun detection and a FWFT receive FIFO.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle, waiting for rxs low (start edge)
// S_START  | half-bit wait, then confirm start bit (reject glitch)
// S_DATA   | shifting DATA_BITS samples in, LSB first
// S_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// S_STOP   | sampling the stop bit; good -> push, low -> framing error
// S_BREAK  | line held low after a bad stop bit; wait for it to rise
module uart_rx_fifo #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RX,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rdy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frm_err,
  output logic                          ovr_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          par_err
`endif
);

  localparam int               AW       = $clog2(FIFO_DEPTH);
  localparam logic [11:0]      HALF_LD  = 12'(CLK_DIV / 2);
  // Reload one short so consecutive samples land exactly CLK_DIV clocks apart.
  localparam logic [11:0]      BIT_LD   = 12'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic                 rx_meta_q, rxs_q;
  state_t               state_q, state_d;
  logic [11:0]          baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_q, push_d;
  logic                 frm_q, frm_d, frm_set;
  logic                 ovr_q, ovr_d, ovr_set;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 sample, full, empty, pop, wr_en;
`ifdef UART_RX_PARITY_EN
  logic                 par_acc_q, par_acc_d;
  logic                 par_q, par_d, par_set;
`endif

  assign sample = (baud_q == 12'd0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q - 12'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    frm_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_d = par_acc_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          baud_d  = HALF_LD;
        end
      end
      S_START: begin
        if (sample) begin
          baud_d = BIT_LD;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = 4'd0;
`ifdef UART_RX_PARITY_EN
            par_acc_d = 1'b0;
`endif
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          baud_d  = BIT_LD;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
`ifdef UART_RX_PARITY_EN
          par_acc_d = par_acc_q ^ rxs_q;
          if (bit_q == LAST_BIT) state_d = S_PARITY;
`else
          if (bit_q == LAST_BIT) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample) begin
          baud_d  = BIT_LD;
          par_set = par_acc_q ^ rxs_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sample) begin
          baud_d = BIT_LD;
          if (rxs_q) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frm_set = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The frame sits in shift_q during the push cycle; the next data sample is far away.
  always_comb begin
    full    = (cnt_q == CNT_FULL);
    empty   = (cnt_q == '0);
    pop     = rd_en && !empty;
    wr_en   = push_q && (!full || pop);
    ovr_set = push_q && full && !pop;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (wr_en) begin
      mem_d[wr_q] = shift_q;
      wr_d        = wr_q + PTR_ONE;
    end
    if (pop) rd_d = rd_q + PTR_ONE;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    frm_d = frm_set | (frm_q & ~clr_err);
    ovr_d = ovr_set | (ovr_q & ~clr_err);
`ifdef UART_RX_PARITY_EN
    par_d = par_set | (par_q & ~clr_err);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef UART_RX_PARITY_EN
      par_acc_q <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
`ifdef UART_RX_PARITY_EN
      par_acc_q <= par_acc_d;
      par_q     <= par_d;
`endif
    end
  end

  assign rx_data = empty ? '0 : mem_q[rd_q];
  assign rdy     = !empty;
  assign count   = cnt_q;
  assign frm_err = frm_q;
  assign ovr_err = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign par_err = par_q;
`endif

endmodule
